// File: rtl/uart_rx_cfg.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_cfg
// Brief    : Parameterised UART receiver with input synchroniser, 3-sample
//            majority voting, false-start rejection and error reporting.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_cfg #(
    parameter int DBITS      = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx,
    input  logic             s_tick,
    output logic [DBITS-1:0] rx_dout,
    output logic             rx_done_tick,
    output logic             parity_err,
    output logic             frame_err,
    output logic             busy
);

    localparam int c_S_W = $clog2(OVERSAMPLE);
    localparam int c_N_W = $clog2(DBITS);

    localparam logic [c_S_W-1:0] c_S_SMP0 = c_S_W'(OVERSAMPLE/2 - 1);
    localparam logic [c_S_W-1:0] c_S_SMP1 = c_S_W'(OVERSAMPLE/2);
    localparam logic [c_S_W-1:0] c_S_DEC  = c_S_W'(OVERSAMPLE/2 + 1);
    localparam logic [c_S_W-1:0] c_S_LAST = c_S_W'(OVERSAMPLE - 1);
    localparam logic [c_N_W-1:0] c_N_LAST = c_N_W'(DBITS - 1);
    localparam logic             c_ODD    = 1'(PARITY_ODD);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
    localparam logic [2:0] c_ST_PARITY = 3'd3;
    localparam logic [2:0] c_ST_STOP   = 3'd4;

    logic             r_rx_sync1, r_rx_s, r_rx_d;
    logic [2:0]       r_state, w_state_nx;
    logic [c_S_W-1:0] r_s, w_s_nx;
    logic [c_N_W-1:0] r_n, w_n_nx;
    logic [DBITS-1:0] r_b, w_b_nx;
    logic             r_smp0, w_smp0_nx, r_smp1, w_smp1_nx;
    logic             r_stop_idx, w_stop_idx_nx;
    logic             r_perr_pend, w_perr_pend_nx, r_ferr_pend, w_ferr_pend_nx;
    logic [DBITS-1:0] w_dout_nx;
    logic             w_perr_out_nx, w_ferr_out_nx, w_done_nx;
    logic             w_maj, w_dec, w_last, w_final_stop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_sync1 <= 1'b1;
            r_rx_s     <= 1'b1;
            r_rx_d     <= 1'b1;
        end else begin
            r_rx_sync1 <= rx;
            r_rx_s     <= r_rx_sync1;
            r_rx_d     <= r_rx_s;
        end
    end

    assign w_maj        = (r_smp0 & r_smp1) | (r_smp0 & r_rx_s) | (r_smp1 & r_rx_s);
    assign w_dec        = s_tick && (r_s == c_S_DEC);
    assign w_last       = s_tick && (r_s == c_S_LAST);
    assign w_final_stop = (STOP_BITS == 1) || r_stop_idx;
    assign busy         = (r_state != c_ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_s          <= '0;
            r_n          <= '0;
            r_b          <= '0;
            r_smp0       <= 1'b1;
            r_smp1       <= 1'b1;
            r_stop_idx   <= 1'b0;
            r_perr_pend  <= 1'b0;
            r_ferr_pend  <= 1'b0;
            rx_dout      <= '0;
            parity_err   <= 1'b0;
            frame_err    <= 1'b0;
            rx_done_tick <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_s          <= w_s_nx;
            r_n          <= w_n_nx;
            r_b          <= w_b_nx;
            r_smp0       <= w_smp0_nx;
            r_smp1       <= w_smp1_nx;
            r_stop_idx   <= w_stop_idx_nx;
            r_perr_pend  <= w_perr_pend_nx;
            r_ferr_pend  <= w_ferr_pend_nx;
            rx_dout      <= w_dout_nx;
            parity_err   <= w_perr_out_nx;
            frame_err    <= w_ferr_out_nx;
            rx_done_tick <= w_done_nx;
        end
    end

    always_comb begin
        w_state_nx     = r_state;
        w_s_nx         = r_s;
        w_n_nx         = r_n;
        w_b_nx         = r_b;
        w_smp0_nx      = r_smp0;
        w_smp1_nx      = r_smp1;
        w_stop_idx_nx  = r_stop_idx;
        w_perr_pend_nx = r_perr_pend;
        w_ferr_pend_nx = r_ferr_pend;
        w_dout_nx      = rx_dout;
        w_perr_out_nx  = parity_err;
        w_ferr_out_nx  = frame_err;
        w_done_nx      = 1'b0;

        // Tick counting and the two early samples are common to every active state
        if ((r_state != c_ST_IDLE) && s_tick) begin
            w_s_nx = r_s + 1'b1;
            if (r_s == c_S_SMP0) w_smp0_nx = r_rx_s;
            if (r_s == c_S_SMP1) w_smp1_nx = r_rx_s;
        end

        case (r_state)
            c_ST_IDLE: begin
                if (r_rx_d && !r_rx_s) begin
                    w_state_nx     = c_ST_START;
                    w_s_nx         = '0;
                    w_perr_pend_nx = 1'b0;
                    w_ferr_pend_nx = 1'b0;
                end
            end
            c_ST_START: begin
                if (w_dec && w_maj) begin
                    w_state_nx = c_ST_IDLE;
                    w_s_nx     = '0;
                end else if (w_last) begin
                    w_state_nx = c_ST_DATA;
                    w_s_nx     = '0;
                    w_n_nx     = '0;
                end
            end
            c_ST_DATA: begin
                if (w_dec) w_b_nx = {w_maj, r_b[DBITS-1:1]};
                if (w_last) begin
                    w_s_nx = '0;
                    if (r_n == c_N_LAST) begin
                        w_state_nx    = (PARITY_EN != 0) ? c_ST_PARITY : c_ST_STOP;
                        w_stop_idx_nx = 1'b0;
                    end else begin
                        w_n_nx = r_n + 1'b1;
                    end
                end
            end
            c_ST_PARITY: begin
                if (w_dec) w_perr_pend_nx = ((^r_b) ^ w_maj) != c_ODD;
                if (w_last) begin
                    w_state_nx    = c_ST_STOP;
                    w_s_nx        = '0;
                    w_stop_idx_nx = 1'b0;
                end
            end
            c_ST_STOP: begin
                // Final stop bit closes at its centre to leave resync margin
                if (w_dec) begin
                    if (!w_maj) w_ferr_pend_nx = 1'b1;
                    if (w_final_stop) begin
                        w_dout_nx     = r_b;
                        w_perr_out_nx = (PARITY_EN != 0) && r_perr_pend;
                        w_ferr_out_nx = r_ferr_pend | !w_maj;
                        w_done_nx     = 1'b1;
                        w_state_nx    = c_ST_IDLE;
                    end
                end else if (w_last) begin
                    w_s_nx        = '0;
                    w_stop_idx_nx = 1'b1;
                end
            end
            default: w_state_nx = c_ST_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_cfg
// Brief    : Bench for uart_rx_cfg in 8N1, 8E1 and 7O2 builds, using a serial
//            line driver and a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_cfg;
    localparam int OS = 16;

    typedef struct packed {
        logic [8:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    typedef struct {
        int         d;
        logic [8:0] data;
        logic       pbit;
        logic [1:0] stops;
        int         gap;
        logic [8:0] x_dout;
        logic       x_pe;
        logic       x_fe;
    } vec_t;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       s_tick = 1'b0;
    logic       rx0 = 1'b1, rx1 = 1'b1, rx2 = 1'b1;
    logic [7:0] dout0, dout1;
    logic [6:0] dout2;
    logic       done0, done1, done2, pe0, pe1, pe2, fe0, fe1, fe2, busy0, busy1, busy2;

    int   n_cmp = 0;
    int   n_err = 0;
    int   tick_div = 4;
    int   tcnt = 0;
    int   done_cnt [3] = '{0, 0, 0};
    int   lat_cnt  [3] = '{0, 0, 0};
    exp_t q0[$], q1[$], q2[$];
    vec_t tv [14];

    uart_rx_cfg u_dut0 (
        .clk(clk), .reset(reset), .rx(rx0), .s_tick(s_tick), .rx_dout(dout0),
        .rx_done_tick(done0), .parity_err(pe0), .frame_err(fe0), .busy(busy0));
    uart_rx_cfg #(.PARITY_EN(1)) u_dut1 (
        .clk(clk), .reset(reset), .rx(rx1), .s_tick(s_tick), .rx_dout(dout1),
        .rx_done_tick(done1), .parity_err(pe1), .frame_err(fe1), .busy(busy1));
    uart_rx_cfg #(.DBITS(7), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_dut2 (
        .clk(clk), .reset(reset), .rx(rx2), .s_tick(s_tick), .rx_dout(dout2),
        .rx_done_tick(done2), .parity_err(pe2), .frame_err(fe2), .busy(busy2));

    always #5 clk = ~clk;

    // Baud tick: one pulse every tick_div clocks, changed just after the edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            tcnt   = (tcnt + 1 >= tick_div) ? 0 : tcnt + 1;
            s_tick = (tcnt == 0);
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int dbits(input int d); return (d == 2) ? 7 : 8; endfunction
    function automatic int pen  (input int d); return (d == 0) ? 0 : 1; endfunction
    function automatic int podd (input int d); return (d == 2) ? 1 : 0; endfunction
    function automatic int stopn(input int d); return (d == 2) ? 2 : 1; endfunction
    function automatic int frame_ticks(input int d);
        return OS * (1 + dbits(d) + pen(d) + stopn(d) - 1) + OS/2 + 2;
    endfunction

    // Frame-level reference: what a receiver must report for the given line bits
    function automatic exp_t model(input int d, input logic [8:0] data,
                                   input logic pbit, input logic [1:0] stops);
        exp_t e;
        int   ones;
        ones = 0;
        e.d  = '0;
        for (int i = 0; i < dbits(d); i++) begin
            e.d[i] = data[i];
            ones  += int'(data[i]);
        end
        e.pe = (pen(d) == 1) && (((ones + int'(pbit)) % 2) != podd(d));
        e.fe = (stops[0] == 1'b0) || ((stopn(d) == 2) && (stops[1] == 1'b0));
        return e;
    endfunction

    function automatic int qsize(input int d);
        case (d)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic qpush(input int d, input exp_t e);
        case (d)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    function automatic exp_t qpop(input int d);
        case (d)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", nm, act, req);
        end
    endtask

    task automatic mon(input int d, input logic done, input logic busy,
                       input logic [8:0] dout, input logic pe, input logic fe);
        exp_t e;
        if (done) begin
            done_cnt[d]++;
            check($sformatf("latency_dut%0d", d), lat_cnt[d], frame_ticks(d));
            check($sformatf("busy_at_done_dut%0d", d), {31'd0, busy}, 0);
            if (qsize(d) == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done_dut%0d: actual dout %0h required no frame", d, dout);
            end else begin
                e = qpop(d);
                check($sformatf("dout_dut%0d", d), {23'd0, dout}, {23'd0, e.d});
                check($sformatf("parity_err_dut%0d", d), {31'd0, pe}, {31'd0, e.pe});
                check($sformatf("frame_err_dut%0d", d), {31'd0, fe}, {31'd0, e.fe});
            end
        end
        if (!busy) lat_cnt[d] = 0;
        else if (s_tick) lat_cnt[d]++;
    endtask

    always @(negedge clk) begin
        mon(0, done0, busy0, {1'b0, dout0}, pe0, fe0);
        mon(1, done1, busy1, {1'b0, dout1}, pe1, fe1);
        mon(2, done2, busy2, {2'b0, dout2}, pe2, fe2);
    end

    task automatic wait_ticks(input int n);
        int k;
        k = 0;
        while (k < n) begin
            @(posedge clk);
            if (s_tick) k++;
        end
    endtask

    task automatic set_rx(input int d, input logic v);
        #2;
        case (d)
            0:       rx0 = v;
            1:       rx1 = v;
            default: rx2 = v;
        endcase
    endtask

    // Serial driver; spike >= 0 inverts the line for one tick at mid-bit of that data bit
    task automatic send_frame(input int d, input logic [8:0] data, input logic pbit,
                              input logic [1:0] stops, input int gap, input int spike);
        set_rx(d, 1'b0);
        wait_ticks(OS);
        for (int i = 0; i < dbits(d); i++) begin
            set_rx(d, data[i]);
            if (i == spike) begin
                wait_ticks(OS/2);
                set_rx(d, ~data[i]);
                wait_ticks(1);
                set_rx(d, data[i]);
                wait_ticks(OS/2 - 1);
            end else begin
                wait_ticks(OS);
            end
        end
        if (pen(d) == 1) begin
            set_rx(d, pbit);
            wait_ticks(OS);
        end
        for (int i = 0; i < stopn(d); i++) begin
            set_rx(d, stops[i]);
            wait_ticks(OS);
        end
        set_rx(d, 1'b1);
        wait_ticks(gap * OS);
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while ((qsize(0) + qsize(1) + qsize(2) != 0 || busy0 || busy1 || busy2) && k < 4000) begin
            @(posedge clk);
            k++;
        end
        #3;
        check("drain_pending", qsize(0) + qsize(1) + qsize(2), 0);
        check("drain_busy", {29'd0, busy0, busy1, busy2}, 0);
        wait_ticks(1);
    endtask

    initial begin
        int         prev;
        int         d;
        int         gap;
        logic [8:0] data;
        logic       pbit;
        logic [1:0] stops;
        exp_t       e;

        //        dut data    p     stops  gap  dout    pe    fe
        tv[0]  = '{0, 9'h0A5, 1'b0, 2'b11, 1, 9'h0A5, 1'b0, 1'b0};
        tv[1]  = '{0, 9'h055, 1'b0, 2'b10, 1, 9'h055, 1'b0, 1'b1};
        tv[2]  = '{0, 9'h000, 1'b0, 2'b11, 0, 9'h000, 1'b0, 1'b0};
        tv[3]  = '{0, 9'h0FF, 1'b0, 2'b11, 1, 9'h0FF, 1'b0, 1'b0};
        tv[4]  = '{1, 9'h03C, 1'b0, 2'b11, 1, 9'h03C, 1'b0, 1'b0};
        tv[5]  = '{1, 9'h03C, 1'b1, 2'b11, 1, 9'h03C, 1'b1, 1'b0};
        tv[6]  = '{1, 9'h001, 1'b1, 2'b11, 0, 9'h001, 1'b0, 1'b0};
        tv[7]  = '{1, 9'h080, 1'b1, 2'b10, 1, 9'h080, 1'b0, 1'b1};
        tv[8]  = '{1, 9'h001, 1'b0, 2'b11, 1, 9'h001, 1'b1, 1'b0};
        tv[9]  = '{2, 9'h07F, 1'b0, 2'b11, 0, 9'h07F, 1'b0, 1'b0};
        tv[10] = '{2, 9'h001, 1'b0, 2'b11, 0, 9'h001, 1'b0, 1'b0};
        tv[11] = '{2, 9'h040, 1'b0, 2'b11, 1, 9'h040, 1'b0, 1'b0};
        tv[12] = '{2, 9'h02A, 1'b1, 2'b11, 1, 9'h02A, 1'b1, 1'b0};
        tv[13] = '{2, 9'h000, 1'b1, 2'b10, 1, 9'h000, 1'b0, 1'b1};

        // Reset state
        repeat (3) @(posedge clk);
        #3;
        check("rst_dout", {24'd0, dout0}, 0);
        check("rst_done", {31'd0, done0}, 0);
        check("rst_perr", {31'd0, pe1}, 0);
        check("rst_ferr", {31'd0, fe2}, 0);
        check("rst_busy", {29'd0, busy0, busy1, busy2}, 0);
        reset = 1'b0;
        wait_ticks(2);

        // Directed frames for all three builds
        for (int i = 0; i < 14; i++) begin
            qpush(tv[i].d, exp_t'{tv[i].x_dout, tv[i].x_pe, tv[i].x_fe});
            send_frame(tv[i].d, tv[i].data, tv[i].pbit, tv[i].stops, tv[i].gap, -1);
        end
        wait_drain();

        // False start: 4-tick low glitch
        prev = done_cnt[0];
        set_rx(0, 1'b0);
        wait_ticks(4);
        #3;
        check("fs_busy_high", {31'd0, busy0}, 1);
        set_rx(0, 1'b1);
        wait_ticks(OS);
        #3;
        check("fs_busy_low", {31'd0, busy0}, 0);
        check("fs_no_done", done_cnt[0], prev);
        wait_ticks(1);

        // Reset during data bit 4 of 0xFF
        prev = done_cnt[0];
        fork
            send_frame(0, 9'h0FF, 1'b0, 2'b11, 1, -1);
            begin
                wait_ticks(5 * OS + OS/2);
                #3;
                reset = 1'b1;
                #1;
                check("midrst_busy", {31'd0, busy0}, 0);
                check("midrst_dout0", {24'd0, dout0}, 0);
                check("midrst_dout1", {24'd0, dout1}, 0);
                check("midrst_perr1", {31'd0, pe1}, 0);
                check("midrst_ferr2", {31'd0, fe2}, 0);
                repeat (2) @(posedge clk);
                #3;
                reset = 1'b0;
            end
        join
        check("midrst_no_done", done_cnt[0], prev);
        qpush(0, exp_t'{9'h081, 1'b0, 1'b0});
        send_frame(0, 9'h081, 1'b0, 2'b11, 1, -1);
        wait_drain();

        // Single-tick spike inside data bit 3 is outvoted
        qpush(0, exp_t'{9'h000, 1'b0, 1'b0});
        send_frame(0, 9'h000, 1'b0, 2'b11, 1, 3);
        wait_drain();

        // Framing error followed by a 40-bit break, then recovery
        prev = done_cnt[0];
        qpush(0, exp_t'{9'h055, 1'b0, 1'b1});
        send_frame(0, 9'h055, 1'b0, 2'b10, 0, -1);
        set_rx(0, 1'b0);
        wait_ticks(40 * OS);
        #3;
        check("break_done_count", done_cnt[0], prev + 1);
        check("break_busy", {31'd0, busy0}, 0);
        set_rx(0, 1'b1);
        wait_ticks(OS);
        qpush(0, exp_t'{9'h012, 1'b0, 1'b0});
        send_frame(0, 9'h012, 1'b0, 2'b11, 1, -1);
        wait_drain();

        // Randomised frames at dense, medium and sparse tick rates
        for (int b = 0; b < 3; b++) begin
            tick_div = (b == 0) ? 1 : ((b == 1) ? 2 : 4);
            wait_ticks(2);
            for (int k = 0; k < 12; k++) begin
                d     = $urandom_range(0, 2);
                data  = 9'($urandom);
                pbit  = 1'($urandom);
                stops = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
                gap   = $urandom_range(0, 2);
                if (stops[stopn(d)-1] == 1'b0 && gap == 0) gap = 1;
                e = model(d, data, pbit, stops);
                qpush(d, e);
                send_frame(d, data, pbit, stops, gap, -1);
            end
            wait_drain();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
